// File: rtl/mult_fu_bank_pkg.sv
// Shared types for the multiply functional-unit bank: request/completion packets,
// the multiply sub-op encoding and the reference result function.
package mult_fu_bank_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned PRF_W = 6;

  typedef enum logic [1:0] {
    MulLo   = 2'd0,
    MulHi   = 2'd1,
    MulHiSu = 2'd2,
    MulHiU  = 2'd3
  } mult_func_e;

  typedef struct packed {
    mult_func_e mult;
  } fu_func_t;

  typedef struct packed {
    logic             valid;
    fu_func_t         fu_func;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [ROB_W-1:0] rob_index;
    logic [PRF_W-1:0] phy_dest_reg;
  } execute_packet_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_index;
    logic [PRF_W-1:0] phy_dest_reg;
    logic [XLEN-1:0]  value;
  } complete_packet_t;

  // Operands are widened to 64 bits with per-op sign extension; the low 64 bits of the
  // product are exact for every signedness combination.
  function automatic logic [XLEN-1:0] mult_result(mult_func_e func, logic [XLEN-1:0] a,
                                                  logic [XLEN-1:0] b);
    logic        sign_a;
    logic        sign_b;
    logic [63:0] wa;
    logic [63:0] wb;
    logic [63:0] prod;
    sign_a = (func != MulHiU) && a[XLEN-1];
    sign_b = (func == MulHi) && b[XLEN-1];
    wa     = {{XLEN{sign_a}}, a};
    wb     = {{XLEN{sign_b}}, b};
    prod   = wa * wb;
    return (func == MulLo) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

endpackage

// File: rtl/mult_fu_bank_pipe.sv
// mult_pipe: one pipelined multiplier unit. STAGES registers deep, the last being the
// output register; the whole unit freezes while that register is full and not drained.
module mult_pipe
  import mult_fu_bank_pkg::*;
#(
  parameter int unsigned STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_func,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [ROB_W-1:0] in_rob_index,
  input  logic [PRF_W-1:0] in_phy_dest_reg,
  input  logic             drain,
  output logic             advance,
  output logic             out_valid,
  output logic [ROB_W-1:0] out_rob_index,
  output logic [PRF_W-1:0] out_phy_dest_reg,
  output logic [XLEN-1:0]  out_value
);

  complete_packet_t stage_q [STAGES];
  complete_packet_t stage_in;

  always_comb begin
    stage_in              = '0;
    stage_in.valid        = in_valid;
    stage_in.rob_index    = in_rob_index;
    stage_in.phy_dest_reg = in_phy_dest_reg;
    stage_in.value        = mult_result(mult_func_e'(in_func), in_opa, in_opb);
  end

  assign advance = !stage_q[STAGES-1].valid || drain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) stage_q[i].valid <= 1'b0;
    end else if (advance) begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_valid        = stage_q[STAGES-1].valid;
  assign out_rob_index    = stage_q[STAGES-1].rob_index;
  assign out_phy_dest_reg = stage_q[STAGES-1].phy_dest_reg;
  assign out_value        = stage_q[STAGES-1].value;

endmodule

// File: rtl/mult_fu_bank.sv
// mult_fu_bank: NUM_UNITS pipelined multipliers with issue-lane mapping and a round-robin
// completion arbiter. Define MULT_STALL_CNT_EN to add the stall_cycles counter output.
module mult_fu_bank
  import mult_fu_bank_pkg::*;
#(
  parameter int unsigned I_WIDTH   = 3,
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned STAGES    = 4,
  parameter int unsigned C_WIDTH   = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  execute_packet_t [I_WIDTH-1:0]   execute,
  output logic [$clog2(I_WIDTH+1)-1:0]    execute_empty_slots,
  output complete_packet_t [C_WIDTH-1:0]  complete,
  input  logic                            complete_ready
`ifdef MULT_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam int unsigned CntW  = $clog2(I_WIDTH + 1);
  localparam int unsigned LaneW = (I_WIDTH > 1) ? $clog2(I_WIDTH) : 1;
  localparam int unsigned PtrW  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] unit_advance;
  logic [NUM_UNITS-1:0] unit_drain;
  logic [NUM_UNITS-1:0] unit_out_valid;
  execute_packet_t      unit_req [NUM_UNITS];
  logic [ROB_W-1:0]     unit_rob [NUM_UNITS];
  logic [PRF_W-1:0]     unit_pdr [NUM_UNITS];
  logic [XLEN-1:0]      unit_value [NUM_UNITS];

  logic [PtrW-1:0]               ptr_q, ptr_d;
  logic                          hold_q;
  logic [C_WIDTH-1:0]            grant_valid, held_valid_q;
  logic [C_WIDTH-1:0][PtrW-1:0]  grant_idx, held_idx_q;

  // The k-th free unit (ascending index) takes lane k; free-ness never looks at execute.
  always_comb begin
    int unsigned free_cnt;
    free_cnt = 0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_req[u] = '0;
      if (unit_advance[u]) begin
        if (free_cnt < I_WIDTH) unit_req[u] = execute[LaneW'(free_cnt)];
        free_cnt++;
      end
    end
    execute_empty_slots = CntW'((free_cnt < I_WIDTH) ? free_cnt : I_WIDTH);
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    mult_pipe #(
      .STAGES(STAGES)
    ) u_pipe (
      .clock           (clock),
      .reset           (reset),
      .flush           (flush),
      .in_valid        (unit_req[u].valid),
      .in_func         (unit_req[u].fu_func.mult),
      .in_opa          (unit_req[u].opa),
      .in_opb          (unit_req[u].opb),
      .in_rob_index    (unit_req[u].rob_index),
      .in_phy_dest_reg (unit_req[u].phy_dest_reg),
      .drain           (unit_drain[u]),
      .advance         (unit_advance[u]),
      .out_valid       (unit_out_valid[u]),
      .out_rob_index   (unit_rob[u]),
      .out_phy_dest_reg(unit_pdr[u]),
      .out_value       (unit_value[u])
    );
  end

  // A refused grant set is replayed verbatim so complete holds steady while not ready.
  always_comb begin
    int              n;
    int              u;
    int              nxt;
    logic [PtrW-1:0] last;
    n           = 0;
    u           = 0;
    nxt         = 0;
    last        = ptr_q;
    grant_valid = '0;
    grant_idx   = '0;
    unit_drain  = '0;
    ptr_d       = ptr_q;
    if (hold_q) begin
      grant_valid = held_valid_q;
      grant_idx   = held_idx_q;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        u = int'(ptr_q) + i;
        if (u >= NUM_UNITS) u -= NUM_UNITS;
        if (unit_out_valid[PtrW'(u)] && (n < C_WIDTH)) begin
          grant_valid[n] = 1'b1;
          grant_idx[n]   = PtrW'(u);
          n++;
        end
      end
    end
    for (int c = 0; c < C_WIDTH; c++) begin
      if (grant_valid[c] && complete_ready) begin
        unit_drain[grant_idx[c]] = 1'b1;
        last                     = grant_idx[c];
      end
    end
    if ((|grant_valid) && complete_ready) begin
      nxt = int'(last) + 1;
      if (nxt >= NUM_UNITS) nxt = 0;
      ptr_d = PtrW'(nxt);
    end
  end

  always_comb begin
    for (int c = 0; c < C_WIDTH; c++) begin
      complete[c] = '0;
      if (grant_valid[c]) begin
        complete[c].valid        = 1'b1;
        complete[c].rob_index    = unit_rob[grant_idx[c]];
        complete[c].phy_dest_reg = unit_pdr[grant_idx[c]];
        complete[c].value        = unit_value[grant_idx[c]];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      hold_q       <= 1'b0;
      held_valid_q <= '0;
      held_idx_q   <= '0;
    end else if (flush) begin
      ptr_q        <= '0;
      hold_q       <= 1'b0;
      held_valid_q <= '0;
      held_idx_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      hold_q       <= (|grant_valid) && !complete_ready;
      held_valid_q <= grant_valid;
      held_idx_q   <= grant_idx;
    end
  end

`ifdef MULT_STALL_CNT_EN
  logic any_stall;
  assign any_stall = |(unit_out_valid & ~unit_drain);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (any_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_fu_bank.sv
// Self-checking bench for mult_fu_bank: directed cases plus randomized traffic scored
// against a tag-keyed reference model of the multiply results.
module tb_mult_fu_bank;
  import mult_fu_bank_pkg::*;

  localparam int unsigned IW = 3;
  localparam int unsigned NU = 2;
  localparam int unsigned ST = 4;
  localparam int unsigned CW = 1;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        flush;
  execute_packet_t [IW-1:0]    execute;
  logic [1:0]                  execute_empty_slots;
  complete_packet_t [CW-1:0]   complete;
  logic                        complete_ready;
`ifdef MULT_STALL_CNT_EN
  logic [31:0]                 stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_val [int];
  logic [5:0]  exp_pdr [int];

  always #5 clock = ~clock;

  mult_fu_bank #(
    .I_WIDTH  (IW),
    .NUM_UNITS(NU),
    .STAGES   (ST),
    .C_WIDTH  (CW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .execute            (execute),
    .execute_empty_slots(execute_empty_slots),
    .complete           (complete),
    .complete_ready     (complete_ready)
`ifdef MULT_STALL_CNT_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic execute_packet_t mk_req(mult_func_e f, logic [31:0] a, logic [31:0] b,
                                             logic [4:0] rob, logic [5:0] pdr);
    execute_packet_t p;
    p              = '0;
    p.valid        = 1'b1;
    p.fu_func.mult = f;
    p.opa          = a;
    p.opb          = b;
    p.rob_index    = rob;
    p.phy_dest_reg = pdr;
    return p;
  endfunction

  // Reference: plain 64-bit integer arithmetic on signed/unsigned views of the operands.
  function automatic logic [31:0] ref_mult(mult_func_e f, logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    longint      p;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      MulHi:   p = sa * sb;
      MulHiSu: p = sa * ub;
      default: p = ua * ub;
    endcase
    pv = p;
    return (f == MulLo) ? pv[31:0] : pv[63:32];
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_single(input string tag, input mult_func_e f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rob,
                            input logic [31:0] exp);
    int lat;
    lat     = 0;
    execute = '0;
    execute[0] = mk_req(f, a, b, rob, 6'(rob + 1));
    step();
    execute = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (complete[0].valid) begin
        lat = i;
        break;
      end
      step();
    end
    check_eq({tag, "_latency"}, lat, ST);
    if (lat != 0) begin
      check_eq({tag, "_value"}, complete[0].value, exp);
      check_eq({tag, "_rob"}, complete[0].rob_index, rob);
      check_eq({tag, "_pdr"}, complete[0].phy_dest_reg, 6'(rob + 1));
      step();
    end
  endtask

  task automatic process_completions();
    for (int c = 0; c < CW; c++) begin
      if (complete[c].valid) begin
        int r;
        r = int'(complete[c].rob_index);
        check_eq("rand_tag_known", exp_val.exists(r), 1);
        if (exp_val.exists(r) && complete_ready) begin
          check_eq("rand_value", complete[c].value, exp_val[r]);
          check_eq("rand_pdr", complete[c].phy_dest_reg, exp_pdr[r]);
          exp_val.delete(r);
          exp_pdr.delete(r);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int                       cnt;
    int unsigned              slots;
    int unsigned              nreq;
    int unsigned              tag;
    mult_func_e               f;
    logic [31:0]              a;
    logic [31:0]              b;
    logic [5:0]               pdr;
    complete_packet_t [CW-1:0] prev_c;
    logic                     prev_ready;
    logic                     prev_flush;

    reset          = 1'b1;
    flush          = 1'b0;
    execute        = '0;
    complete_ready = 1'b1;
    #3;
    check_eq("reset_complete", complete, '0);
    check_eq("reset_slots", execute_empty_slots, 2);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    @(negedge clock);
    check_eq("idle_slots", execute_empty_slots, 2);
    check_eq("idle_valid", complete[0].valid, 0);
    step();

    run_single("mul_7x6", MulLo, 32'd7, 32'd6, 5'd5, 32'd42);
    run_single("mulh_min", MulHi, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000);
    run_single("mulhu_max", MulHiU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE);
    run_single("mulhsu_neg", MulHiSu, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'hFFFF_FFFF);

    // Two requests held back by a stalled consumer, then released.
    flush = 1'b1;
    step();
    flush          = 1'b0;
    complete_ready = 1'b0;
    execute[0]     = mk_req(MulLo, 32'd3, 32'd5, 5'd1, 6'd1);
    execute[1]     = mk_req(MulLo, 32'd4, 32'd5, 5'd2, 6'd2);
    step();
    execute = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock);
      if (cyc < ST) begin
        check_eq("stall_fill_slots", execute_empty_slots, 2);
      end else begin
        check_eq("stall_full_slots", execute_empty_slots, 0);
        check_eq("stall_valid", complete[0].valid, 1);
        check_eq("stall_hold_rob", complete[0].rob_index, 1);
      end
      step();
    end
    complete_ready = 1'b1;
    @(negedge clock);
    check_eq("release0_rob", complete[0].rob_index, 1);
    check_eq("release0_value", complete[0].value, 15);
    check_eq("release0_slots", execute_empty_slots, 1);
    step();
    @(negedge clock);
    check_eq("release1_valid", complete[0].valid, 1);
    check_eq("release1_rob", complete[0].rob_index, 2);
    check_eq("release1_value", complete[0].value, 20);
    step();
    @(negedge clock);
    check_eq("release_done", complete[0].valid, 0);
    step();

    // Back-to-back traffic on both units, flushed in the fourth cycle.
    for (int c = 0; c < 4; c++) begin
      execute[0] = mk_req(MulLo, 32'(c + 2), 32'd3, 5'(10 + 2 * c), 6'd3);
      execute[1] = mk_req(MulHiU, 32'(c + 9), 32'd3, 5'(11 + 2 * c), 6'd4);
      if (c == 3) begin
        flush = 1'b1;
        @(negedge clock);
        check_eq("flush_cycle_slots", execute_empty_slots, 2);
      end
      step();
    end
    execute = '0;
    flush   = 1'b0;
    cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (complete[0].valid) cnt++;
      step();
    end
    check_eq("flush_no_complete", cnt, 0);
    run_single("post_flush", MulLo, 32'd123, 32'd456, 5'd20, 32'd56088);

    // Asynchronous reset while work is in flight.
    execute[0] = mk_req(MulLo, 32'd9, 32'd9, 5'd21, 6'd1);
    step();
    execute = '0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset_complete", complete, '0);
    check_eq("midreset_slots", execute_empty_slots, 2);
    #1;
    reset = 1'b0;
    step();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (complete[0].valid) cnt++;
      step();
    end
    check_eq("midreset_discard", cnt, 0);

    // Randomized traffic, random back-pressure and occasional flushes.
    tag        = 0;
    prev_c     = '0;
    prev_ready = 1'b1;
    prev_flush = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      execute        = '0;
      complete_ready = ($urandom_range(3) != 0);
      flush          = ($urandom_range(79) == 0);
      #1;
      slots = execute_empty_slots;
      nreq  = $urandom_range(slots);
      for (int k = 0; k < IW; k++) begin
        if (k < nreq) begin
          f          = mult_func_e'($urandom_range(3));
          a          = pick_op();
          b          = pick_op();
          pdr        = 6'($urandom);
          execute[k] = mk_req(f, a, b, 5'(tag), pdr);
          if (!flush) begin
            exp_val[int'(5'(tag))] = ref_mult(f, a, b);
            exp_pdr[int'(5'(tag))] = pdr;
          end
          tag++;
        end
      end
      #1;
      check_eq("rand_slots_indep", execute_empty_slots, slots);
      @(negedge clock);
      if (!prev_ready && !prev_flush && (|prev_c[0].valid)) begin
        check_eq("rand_stable", complete, prev_c);
      end
      process_completions();
      if (flush) begin
        exp_val.delete();
        exp_pdr.delete();
      end
      prev_c     = complete;
      prev_ready = complete_ready;
      prev_flush = flush;
      step();
    end
    execute        = '0;
    flush          = 1'b0;
    complete_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      process_completions();
      step();
    end
    check_eq("rand_all_completed", exp_val.num(), 0);

`ifdef MULT_STALL_CNT_EN
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    complete_ready = 1'b0;
    execute[0]     = mk_req(MulLo, 32'd2, 32'd2, 5'd3, 6'd3);
    step();
    execute = '0;
    repeat (ST - 1) step();
    repeat (5) step();
    @(negedge clock);
    check_eq("stall_cnt_5", stall_cycles, 5);
    #1;
    reset = 1'b1;
    #1;
    check_eq("stall_cnt_reset", stall_cycles, 0);
    check_eq("stall_reset_complete", complete, '0);
    #1;
    reset          = 1'b0;
    complete_ready = 1'b1;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_fu_bank.md
MULT_FU_BANK -- requirements
Module: mult_fu_bank

Interface
REQ-001 SHALL have parameter I_WIDTH, default 3, meaning number of execute lanes driven by the issue queue for FU_MULT.
REQ-002 SHALL have parameter NUM_UNITS, default 2, meaning number of independent pipelined multipliers.
REQ-003 SHALL have parameter STAGES, default 4, meaning multiplier latency in cycles; legal range 1..8.
REQ-004 SHALL have parameter C_WIDTH, default 1, meaning completion lanes per cycle.
REQ-005 SHALL use one clock; reset is asynchronous and active-high: ports clock and reset.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  synchronous squash of all in-flight work.
REQ-009 execute  input  execute_packet_t [I_WIDTH-1:0]  multiply requests; valid lanes contiguous from lane 0.
REQ-010 execute_empty_slots  output  `CAL_CNT_LEN(I_WIDTH)  requests acceptable this cycle.
REQ-011 complete  output  complete_packet_t [C_WIDTH-1:0]  finished results (valid, rob_index, phy_dest_reg, value).
REQ-012 complete_ready  input  1  consumer accepts all valid complete lanes this cycle.

Function
REQ-013 Unit u SHALL be free iff its stage-0 advances this cycle: out_valid[u]==0, or u is granted while complete_ready==1.
REQ-014 execute_empty_slots SHALL equal min(I_WIDTH, free-unit count) and SHALL NOT depend combinationally on execute.
REQ-015 Valid lane k SHALL be captured by the k-th free unit in ascending unit index; lanes beyond free count are a protocol error (ignored).
REQ-016 Result SHALL be per fu_func.mult: MUL low 32 of opa*opb; MULH high 32 signed*signed; MULHSU high 32 signed*unsigned; MULHU high 32 unsigned*unsigned.
REQ-017 A request accepted in cycle N SHALL reach out_valid in cycle N+STAGES when unstalled; each unit holds one output register.
REQ-018 A unit whose output register is full and not granted SHALL stall all its stages; no entry is dropped or duplicated.
REQ-019 Completion arbitration SHALL grant up to C_WIDTH out_valid units round-robin, pointer advancing past the last granted unit only when complete_ready==1.
REQ-020 Granted results SHALL occupy complete lanes 0..g-1 in grant order; other lanes valid=0.
REQ-021 complete SHALL be stable while complete_ready==0.
REQ-022 flush SHALL clear all stage valids, output registers and arbiter pointer at the next edge; requests presented with flush are discarded; execute_empty_slots is unaffected in the flush cycle.
REQ-023 rob_index and phy_dest_reg SHALL travel unmodified with their operands.

Reset
REQ-024 reset SHALL asynchronously clear all valids, output registers and arbiter pointer to 0; complete all-zero; execute_empty_slots = min(I_WIDTH, NUM_UNITS).
REQ-025 reset asserted mid-operation SHALL discard all in-flight results.

Configuration
REQ-026 With MULT_STALL_CNT_EN defined, SHALL add output stall_cycles (32 bits) counting cycles with any unit stalled, saturating at 2^32-1, cleared by reset (not flush).
REQ-027 Without MULT_STALL_CNT_EN, port and counter SHALL be absent; behaviour otherwise identical.

Structure
REQ-028 complete_packet_t and the fu_func.mult encoding SHALL be in shared headers (sys_defs.svh / execute.svh), not in this module.
REQ-029 One sub-module mult_pipe SHALL implement a single unit (stages, stall, output register); mult_fu_bank instantiates NUM_UNITS copies plus lane mapping and arbiter.

Verification
REQ-030 Reset, then idle: execute_empty_slots==2, complete all valid=0.
REQ-031 Lane0 MUL opa=7 opb=6, complete_ready=1: complete[0].value==42 exactly 4 cycles later, correct rob_index.
REQ-032 MULH opa=0x80000000 opb=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-033 Two same-cycle requests, complete_ready=0 for 10 cycles: both stall, execute_empty_slots==0 once outputs full; release -> both complete over 2 cycles, round-robin order.
REQ-034 Back-to-back requests every cycle to both units, then flush at cycle 3: no complete.valid afterward; new request after flush returns correct value.
REQ-035 With MULT_STALL_CNT_EN, 5 stalled cycles -> stall_cycles==5; reset mid-stall -> 0.
